// File: rtl/ark_pkg.sv
// ark_pkg: shared definitions for the AddRoundKey stream block.
//   - ARK_DATA_W / ARK_NUM_KEYS : default state width and round-key bank depth
//   - skid_state_e              : occupancy of the two-entry output buffer
//   - kidx_w_for()              : key index width needed to address a bank
package ark_pkg;

  localparam int ARK_DATA_W   = 128;
  localparam int ARK_NUM_KEYS = 11;

  // EMPTY: nothing buffered, ONE: main register valid, TWO: main + skid valid
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  // Smallest index width able to address n entries (at least 1 bit).
  function automatic int kidx_w_for(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/ark_key_bank.sv
// ark_key_bank: round-key storage.
//   clk, rst : clock, asynchronous active-high reset (clears every entry)
//   we, waddr, wdata : single write port; out-of-range addresses are dropped
//   raddr, rdata     : combinational read port; out-of-range reads return 0
// A write becomes visible on rdata from the cycle after the write edge, so a
// same-cycle read returns the old contents.
module ark_key_bank import ark_pkg::*; #(
  parameter int DATA_W   = ARK_DATA_W,
  parameter int NUM_KEYS = ARK_NUM_KEYS,
  parameter int KIDX_W   = kidx_w_for(NUM_KEYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [KIDX_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [KIDX_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam logic [KIDX_W:0] NK = (KIDX_W+1)'(NUM_KEYS);

  logic [DATA_W-1:0] mem [NUM_KEYS];

  logic waddr_ok;
  logic raddr_ok;

  assign waddr_ok = ({1'b0, waddr} < NK);
  assign raddr_ok = ({1'b0, raddr} < NK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_KEYS; i++) mem[i] <= '0;
    end else if (we && waddr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  // Out-of-range index reads as an all-zero key: data passes unchanged.
  assign rdata = raddr_ok ? mem[raddr] : '0;

endmodule

// File: rtl/ark_stream.sv
// ark_stream: streaming AddRoundKey (out_data = in_data XOR bank[in_kidx]).
//   clk, rst                     : clock, asynchronous active-high reset
//   key_we, key_waddr, key_wdata : round-key bank write port (never stalls flow)
//   in_valid, in_ready, in_data, in_kidx     : input stream
//   out_valid, out_ready, out_data, out_kidx : output stream
//   err_kidx  : one-cycle pulse the cycle after accepting an out-of-range index
//   state_dbg : current buffer occupancy state (skid_state_e encoding)
//
// Handshake: a beat moves on a rising edge where valid and ready are both
// high; valid, once raised, holds with its payload stable until that edge.
//
// The XOR happens at acceptance, so the key captured is the bank content
// before any same-cycle write. Results sit in a main register with a skid
// register behind it; in_ready is registered and only drops when both are
// full, which keeps full throughput without a combinational ready path.
module ark_stream import ark_pkg::*; #(
  parameter int DATA_W   = ARK_DATA_W,
  parameter int NUM_KEYS = ARK_NUM_KEYS,
  parameter int KIDX_W   = kidx_w_for(NUM_KEYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_we,
  input  logic [KIDX_W-1:0] key_waddr,
  input  logic [DATA_W-1:0] key_wdata,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KIDX_W-1:0] in_kidx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [KIDX_W-1:0] out_kidx,
  output logic              err_kidx,
  output logic [1:0]        state_dbg
);

  localparam logic [KIDX_W:0] NK = (KIDX_W+1)'(NUM_KEYS);

  skid_state_e       state;
  skid_state_e       next_state;
  logic [DATA_W-1:0] key_rdata;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] main_data;
  logic [KIDX_W-1:0] main_kidx;
  logic [DATA_W-1:0] skid_data;
  logic [KIDX_W-1:0] skid_kidx;
  logic              accept;
  logic              drain;
  logic              kidx_bad;

  ark_key_bank #(
    .DATA_W   (DATA_W),
    .NUM_KEYS (NUM_KEYS),
    .KIDX_W   (KIDX_W)
  ) u_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (key_we),
    .waddr (key_waddr),
    .wdata (key_wdata),
    .raddr (in_kidx),
    .rdata (key_rdata)
  );

  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;
  assign result   = in_data ^ key_rdata;
  assign kidx_bad = ({1'b0, in_kidx} >= NK);

  always_comb begin
    next_state = state;
    unique case (state)
      EMPTY: if (accept) next_state = ONE;
      ONE: begin
        if (accept && !drain)      next_state = TWO;
        else if (!accept && drain) next_state = EMPTY;
      end
      TWO:     if (drain) next_state = ONE;
      default: next_state = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      err_kidx  <= 1'b0;
      main_data <= '0;
      main_kidx <= '0;
      skid_data <= '0;
      skid_kidx <= '0;
    end else begin
      state     <= next_state;
      // Ready/valid follow the state being entered, so they stay registered.
      in_ready  <= (next_state != TWO);
      out_valid <= (next_state != EMPTY);
      err_kidx  <= accept && kidx_bad;
      unique case (state)
        EMPTY: begin
          if (accept) begin
            main_data <= result;
            main_kidx <= in_kidx;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_data <= result;
            main_kidx <= in_kidx;
          end else if (accept) begin
            // Main is still waiting downstream; park the new beat behind it.
            skid_data <= result;
            skid_kidx <= in_kidx;
          end
        end
        TWO: begin
          if (drain) begin
            main_data <= skid_data;
            main_kidx <= skid_kidx;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data  = main_data;
  assign out_kidx  = main_kidx;
  assign state_dbg = state;

endmodule

// File: tb/tb_ark_stream.sv
module tb_ark_stream;

  localparam int DATA_W   = 128;
  localparam int NUM_KEYS = 11;
  localparam int KIDX_W   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              key_we = 1'b0;
  logic [KIDX_W-1:0] key_waddr = '0;
  logic [DATA_W-1:0] key_wdata = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [KIDX_W-1:0] in_kidx = '0;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [KIDX_W-1:0] out_kidx;
  logic              err_kidx;
  logic [1:0]        state_dbg;

  ark_stream #(
    .DATA_W   (DATA_W),
    .NUM_KEYS (NUM_KEYS),
    .KIDX_W   (KIDX_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_we    (key_we),
    .key_waddr (key_waddr),
    .key_wdata (key_wdata),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_kidx   (in_kidx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_kidx  (out_kidx),
    .err_kidx  (err_kidx),
    .state_dbg (state_dbg)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  // Model: a key array and a FIFO of results accepted but not yet taken.
  logic [DATA_W-1:0]        mkey [NUM_KEYS];
  logic [KIDX_W+DATA_W-1:0] exp_q[$];
  logic                     err_exp    = 1'b0;
  logic                     ready_hold = 1'b1;

  function automatic logic [DATA_W-1:0] model_key(input logic [KIDX_W-1:0] k);
    if (int'(k) < NUM_KEYS) return mkey[k];
    return '0;
  endfunction

  always @(negedge clk) begin
    logic exp_rdy;
    logic exp_vld;
    if (rst) begin
      chk("rst_out_valid", DATA_W'(out_valid), '0);
      chk("rst_in_ready", DATA_W'(in_ready), '0);
      chk("rst_err_kidx", DATA_W'(err_kidx), '0);
      chk("rst_out_data", out_data, '0);
      chk("rst_out_kidx", DATA_W'(out_kidx), '0);
      exp_q.delete();
      err_exp    = 1'b0;
      ready_hold = 1'b1;
      for (int i = 0; i < NUM_KEYS; i++) mkey[i] = '0;
    end else begin
      // At most two results may be outstanding; ready needs one edge after reset.
      exp_rdy = ready_hold ? 1'b0 : (exp_q.size() < 2);
      exp_vld = (exp_q.size() > 0);
      chk("in_ready", DATA_W'(in_ready), DATA_W'(exp_rdy));
      chk("out_valid", DATA_W'(out_valid), DATA_W'(exp_vld));
      if (exp_vld) begin
        chk("out_data", out_data, exp_q[0][DATA_W-1:0]);
        chk("out_kidx", DATA_W'(out_kidx), DATA_W'(exp_q[0][KIDX_W+DATA_W-1:DATA_W]));
      end
      chk("err_kidx", DATA_W'(err_kidx), DATA_W'(err_exp));
      // Predict the effect of the coming edge.
      err_exp = 1'b0;
      if (exp_vld && out_ready) void'(exp_q.pop_front());
      if (in_valid && exp_rdy) begin
        exp_q.push_back({in_kidx, in_data ^ model_key(in_kidx)});
        err_exp = (int'(in_kidx) >= NUM_KEYS);
      end
      if (key_we && int'(key_waddr) < NUM_KEYS) mkey[key_waddr] = key_wdata;
      ready_hold = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  int or_mode = 1;  // 0: always ready, 1: never ready, 2: random
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_key(input logic [KIDX_W-1:0] a, input logic [DATA_W-1:0] d);
    key_we = 1'b1; key_waddr = a; key_wdata = d;
    step();
    key_we = 1'b0;
  endtask

  // Offer one beat and hold it until an edge accepts it.
  task automatic send(input logic [DATA_W-1:0] d, input logic [KIDX_W-1:0] k);
    logic rdy;
    int   b;
    in_valid = 1'b1; in_data = d; in_kidx = k;
    b = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      key_we = 1'b0;
      b++;
    end while (!rdy && b < 50);
    in_valid = 1'b0;
    if (!rdy) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: got no acceptance expected acceptance within 50 cycles");
    end
  endtask

  task automatic wait_empty();
    int b = 0;
    while (exp_q.size() != 0 && b < 300) begin
      step();
      b++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0", exp_q.size());
    end
  endtask

  // ---------------- directed stimulus ----------------
  logic [DATA_W-1:0] d;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("ready_before_edge", DATA_W'(in_ready), '0);
    step();
    chk("ready_after_edge", DATA_W'(in_ready), 128'd1);
    or_mode = 0;

    // Known-answer vector.
    write_key(4'd0, 128'h000102030405060708090a0b0c0d0e0f);
    send(128'h00112233445566778899aabbccddeeff, 4'd0);
    chk("kat_valid", DATA_W'(out_valid), 128'd1);
    chk("kat_data", out_data, 128'h00102030405060708090a0b0c0d0e0f0);
    wait_empty();

    // Fill the rest of the bank, then 20 back-to-back beats with random drain.
    for (int i = 1; i < NUM_KEYS; i++) write_key(4'(i), {16{8'(i * 17)}});
    or_mode = 2;
    for (int i = 0; i < 20; i++) send({$urandom, $urandom, $urandom, $urandom}, 4'(i % NUM_KEYS));
    or_mode = 0;
    wait_empty();

    // Same-cycle write and acceptance: old key applies, new key from next beat.
    write_key(4'd3, '0);
    d = 128'h0123456789abcdeffedcba9876543210;
    key_we = 1'b1; key_waddr = 4'd3; key_wdata = '1;
    send(d, 4'd3);
    chk("rbw_old_key", out_data, 128'h0123456789abcdeffedcba9876543210);
    send(d, 4'd3);
    chk("rbw_new_key", out_data, 128'hfedcba98765432100123456789abcdef);
    wait_empty();

    // Out-of-range index passes data through and pulses err_kidx once.
    send({16{8'ha5}}, 4'd12);
    chk("oor_data", out_data, {16{8'ha5}});
    chk("oor_err_pulse", DATA_W'(err_kidx), 128'd1);
    step();
    chk("oor_err_clear", DATA_W'(err_kidx), '0);
    wait_empty();

    // Out-of-range write is dropped; read every entry back via zero data.
    write_key(4'd14, {4{32'hdeadbeef}});
    for (int i = 0; i < NUM_KEYS; i++) send('0, 4'(i));
    wait_empty();
    send('0, 4'd0);
    chk("readback_key0", out_data, 128'h000102030405060708090a0b0c0d0e0f);
    wait_empty();

    // Two beats buffered, then reset mid-cycle.
    or_mode = 1;
    step();
    send(128'h1111, 4'd1);
    send(128'h2222, 4'd2);
    step();
    chk("two_full_ready", DATA_W'(in_ready), '0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", DATA_W'(out_valid), '0);
    chk("async_rst_ready", DATA_W'(in_ready), '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    or_mode = 0;
    step();
    chk("post_rst_ready", DATA_W'(in_ready), 128'd1);
    chk("post_rst_valid", DATA_W'(out_valid), '0);
    repeat (4) step();
    chk("no_stale_beat", DATA_W'(out_valid), '0);
    // Bank was cleared by reset: key 1 is zero again.
    send(128'h5a5a, 4'd1);
    chk("bank_cleared", out_data, 128'h5a5a);
    wait_empty();

    // Final random-drain burst.
    or_mode = 2;
    for (int i = 0; i < 8; i++) send({$urandom, $urandom, $urandom, $urandom}, 4'($urandom_range(0, 15)));
    or_mode = 0;
    wait_empty();
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ark_stream.md
ARK_STREAM -- requirements
Module: ark_stream

Interface
REQ-001 Parameter DATA_W, default 128, state/key word width in bits; multiple of 8.
REQ-002 Parameter NUM_KEYS, default 11, round-key bank depth (11/13/15 for AES-128/192/256).
REQ-003 Parameter KIDX_W, default 4, key index width; SHALL satisfy 2**KIDX_W >= NUM_KEYS.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 key_we  input  1  round-key bank write strobe.
REQ-007 key_waddr  input  KIDX_W  bank write index.
REQ-008 key_wdata  input  DATA_W  round-key value to write.
REQ-009 in_valid  input  1  input beat offered.
REQ-010 in_ready  output  1  input beat accepted when in_valid and in_ready are both high.
REQ-011 in_data  input  DATA_W  state block.
REQ-012 in_kidx  input  KIDX_W  round-key index applied to this beat.
REQ-013 out_valid  output  1  result beat offered.
REQ-014 out_ready  input  1  downstream accepts when out_valid and out_ready are both high.
REQ-015 out_data  output  DATA_W  in_data XOR bank[in_kidx].
REQ-016 out_kidx  output  KIDX_W  index carried alongside the result.
REQ-017 err_kidx  output  1  one-cycle pulse on acceptance of a beat with in_kidx >= NUM_KEYS.

Function
REQ-018 Result SHALL equal in_data XOR bank[in_kidx], bitwise over DATA_W; out-of-range index SHALL use an all-zero key, passing data unchanged.
REQ-019 Latency: an accepted beat SHALL appear on out_data in the cycle after acceptance when the output is empty; throughput is 1 beat/cycle under continuous out_ready.
REQ-020 Buffering: 2-entry skid (main + skid register); FSM states EMPTY, ONE, TWO.
REQ-021 EMPTY: accept -> ONE.
REQ-022 ONE: accept with no drain -> TWO; drain with no accept -> EMPTY; accept with drain, or neither -> ONE.
REQ-023 TWO: drain -> ONE, with the skid entry moving to main; no accept is possible.
REQ-024 in_ready SHALL be registered and SHALL be high exactly when state != TWO; out_valid SHALL be high exactly when state != EMPTY.
REQ-025 Order SHALL be preserved; no beat dropped or duplicated under any in_valid/out_ready pattern.
REQ-026 While out_valid is high and out_ready is low, out_data and out_kidx SHALL hold stable.
REQ-027 The XOR SHALL be computed at acceptance; the key value captured is the bank content before any same-cycle write (read-before-write).
REQ-028 A bank write SHALL take effect from the next cycle; writes with key_waddr >= NUM_KEYS SHALL be ignored.
REQ-029 Bank writes are independent of the stream handshake and never stall it.
REQ-030 err_kidx SHALL be registered, asserted the cycle after the offending acceptance, and SHALL not affect flow.

Reset
REQ-031 On rst high, state SHALL go to EMPTY immediately (asynchronous).
REQ-032 During reset, out_valid, in_ready, err_kidx, out_data and out_kidx SHALL all be 0, and every bank entry SHALL be 0.
REQ-033 in_ready SHALL rise on the first clock edge after rst deasserts.
REQ-034 In-flight beats SHALL be discarded by a mid-stream reset; nothing is replayed afterwards.

Structure
REQ-035 Package ark_pkg SHALL hold the DATA_W/NUM_KEYS defaults, the FSM state enum (EMPTY, ONE, TWO) and a function deriving KIDX_W from NUM_KEYS.
REQ-036 The key bank SHALL be a sub-module, ark_key_bank: flop array, one write port, one combinational read port, async reset.
REQ-037 The skid FSM and the XOR SHALL reside in ark_stream.

Verification
REQ-038 Bank[0]=000102030405060708090a0b0c0d0e0f; in_data=00112233445566778899aabbccddeeff, kidx 0 -> out_data=00102030405060708090a0b0c0d0e0f0 one cycle after acceptance.
REQ-039 Feed 20 back-to-back beats with kidx 0..10 cycling and out_ready toggling pseudo-randomly -> all 20 results in order and correct; in_ready low only in TWO.
REQ-040 Same-cycle key_we to bank[3]=FF..FF while accepting a kidx-3 beat with old key 00..00 -> result uses 00..00; the next kidx-3 beat uses FF..FF.
REQ-041 in_kidx=12 with NUM_KEYS=11, data=A5..A5 -> out_data=A5..A5; err_kidx pulses for exactly one cycle.
REQ-042 Hold out_ready low with two beats buffered, then assert rst mid-cycle -> out_valid=0 immediately; after release, in_ready=1 on the next edge and no stale beat emerges.
REQ-043 Write key_waddr=14 (NUM_KEYS=11) -> all bank entries unchanged, verified by reading every index.
